// File: rtl/piso_pkg.sv
// piso_pkg: shared state type, default sizes and round-robin pick for piso_tx_scheduler.
package piso_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF = 4;
  localparam int MAX_REQ = 16;
  localparam int MAX_ID_W = 4;
  typedef enum logic {IDLE, SHIFT} state_e;
  typedef struct packed {
    logic found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;
  // First valid index at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input logic [MAX_ID_W-1:0] ptr, input int n);
    rr_pick_t r;
    int k;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = (int'(ptr) + i) % n;
      if (i < n && !r.found && valid[MAX_ID_W'(k)]) begin
        r.found = 1'b1;
        r.idx = MAX_ID_W'(k);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/piso_shift_core.sv
// piso_shift_core: MSB-first parallel-in/serial-out shift register.
module piso_shift_core #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] parallel_in,
  output logic              serial_out
);
  logic [DATA_W-1:0] shreg_q, shreg_d;
  always_comb shreg_d = load ? parallel_in : shift_en ? {shreg_q[DATA_W-2:0], 1'b0} : shreg_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) shreg_q <= '0;
    else shreg_q <= shreg_d;
  assign serial_out = shreg_q[DATA_W-1];
endmodule

// File: rtl/piso_tx_scheduler.sv
// piso_tx_scheduler: round-robin arbiter feeding one shared MSB-first serializer, gapless back-to-back.
module piso_tx_scheduler import piso_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      serial_out,
  output logic                      serial_valid,
  output logic                      frame_start,
  output logic [ID_W-1:0]           active_id,
  output logic                      busy
);
  localparam int CNT_W = $clog2(DATA_W);
  state_e state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, active_id_q, active_id_d, win_id;
  logic frame_start_q, frame_start_d;
  logic shifting, last_bit, arb_en, grant, core_out;
  logic [DATA_W-1:0] word;
  rr_pick_t pick;
  // Arbitration is open in IDLE and on the last bit, so a reload keeps the stream gapless.
  always_comb begin
    shifting = state_q == SHIFT;
    last_bit = shifting && bit_cnt_q == CNT_W'(DATA_W - 1);
    arb_en = !shifting || last_bit;
    pick = rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(rr_ptr_q), NUM_REQ);
    win_id = ID_W'(pick.idx);
    grant = arb_en && pick.found && !rst;
    req_ready = grant ? NUM_REQ'(1) << win_id : '0;
    word = req_data[int'(win_id)*DATA_W +: DATA_W];
    rr_ptr_d = !grant ? rr_ptr_q : win_id == ID_W'(NUM_REQ - 1) ? '0 : win_id + 1'b1;
    active_id_d = grant ? win_id : active_id_q;
    frame_start_d = grant;
    state_d = grant || (shifting && !last_bit) ? SHIFT : IDLE;
    bit_cnt_d = !grant && shifting && !last_bit ? bit_cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      rr_ptr_q <= '0;
      active_id_q <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rr_ptr_q <= rr_ptr_d;
      active_id_q <= active_id_d;
      frame_start_q <= frame_start_d;
    end
  piso_shift_core #(.DATA_W(DATA_W)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (grant),
    .shift_en   (shifting),
    .parallel_in(word),
    .serial_out (core_out)
  );
  assign serial_valid = shifting;
  assign busy = shifting;
  assign serial_out = core_out & shifting;
  assign frame_start = frame_start_q;
  assign active_id = active_id_q;
endmodule

// File: tb/tb_piso_tx_scheduler.sv
// tb_piso_tx_scheduler: directed checks of arbitration, serial stream and reset behaviour.
module tb_piso_tx_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [15:0] req_data = '0;
  logic [3:0] req_ready;
  logic serial_out, serial_valid, frame_start, busy;
  logic [1:0] active_id;
  logic [1:0] v2 = '0;
  logic [3:0] d2 = '0;
  logic [1:0] rdy2;
  logic so2, sv2, fs2, busy2;
  logic id2;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  piso_tx_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .serial_out(serial_out), .serial_valid(serial_valid), .frame_start(frame_start),
    .active_id(active_id), .busy(busy)
  );
  piso_tx_scheduler #(.NUM_REQ(2), .DATA_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_data(d2), .req_ready(rdy2),
    .serial_out(so2), .serial_valid(sv2), .frame_start(fs2), .active_id(id2), .busy(busy2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    v2 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic drain();
    req_valid = '0;
    repeat (6) @(negedge clk);
    #1 chk("drain_busy", busy, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [15:0] s;
    logic [3:0] w;
    int seq [5];
    // reset state, req_ready held low while rst is high
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_valid", serial_valid, 1'b0);
    chk("rst_out", serial_out, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_id", active_id, 2'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    // single word 1011 from req0
    @(negedge clk);
    req_valid = 4'b0001;
    req_data[3:0] = 4'hB;
    #1 chk("t1_ready", req_ready, 4'b0001);
    w = 4'hB;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("t1_bit", serial_out, w[3-k]);
      chk("t1_valid", serial_valid, 1'b1);
      chk("t1_fs", frame_start, k == 0);
      chk("t1_id", active_id, 2'd0);
      chk("t1_ready_off", req_ready, 4'h0);
    end
    @(negedge clk);
    #1;
    chk("t1_idle_valid", serial_valid, 1'b0);
    chk("t1_idle_out", serial_out, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);
    // all four continuously valid: 16 gapless bits, grants 0,1,2,3,0
    do_reset();
    @(negedge clk);
    req_valid = 4'hF;
    req_data = 16'h0F5A;
    #1 chk("t2_ready0", req_ready, 4'b0001);
    s = 16'hA5F0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      chk("t2_bit", serial_out, s[15-k]);
      chk("t2_valid", serial_valid, 1'b1);
      chk("t2_fs", frame_start, k % 4 == 0);
      chk("t2_id", active_id, k / 4);
      chk("t2_ready", req_ready, (k % 4 == 3) ? (32'd1 << ((k / 4 + 1) % 4)) : 32'd0);
    end
    @(negedge clk);
    #1;
    chk("t2_wrap_id", active_id, 2'd0);
    chk("t2_wrap_fs", frame_start, 1'b1);
    chk("t2_wrap_bit", serial_out, 1'b1);
    drain();
    // rotation fairness between req1 and req3
    do_reset();
    seq = '{3, 1, 3, 1, 3};
    @(negedge clk);
    req_valid = 4'b1000;
    #1 chk("t3_ready0", req_ready, 4'b1000);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      req_valid = 4'b1010;
      #1;
      if (k % 4 == 0) chk("t3_id", active_id, seq[k/4]);
      chk("t3_ready", req_ready, (k % 4 == 3) ? (32'd1 << seq[k/4+1]) : 32'd0);
    end
    drain();
    // late arrival of req2 during req0's frame
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    req_data = 16'h030C;
    #1 chk("t4_ready0", req_ready, 4'b0001);
    s = 16'h00C3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = (k >= 1 && k <= 3) ? 4'b0100 : 4'b0000;
      #1;
      chk("t4_bit", serial_out, s[7-k]);
      chk("t4_valid", serial_valid, 1'b1);
      chk("t4_fs", frame_start, k % 4 == 0);
      chk("t4_id", active_id, k < 4 ? 2'd0 : 2'd2);
      chk("t4_ready", req_ready, k == 3 ? 4'b0100 : 4'b0000);
    end
    @(negedge clk);
    #1 chk("t4_idle", serial_valid, 1'b0);
    // asynchronous reset during the second bit
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    req_data = 16'h00AF;
    #1 chk("t5_ready0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1 chk("t5_pre_valid", serial_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", serial_valid, 1'b0);
    chk("t5_out", serial_out, 1'b0);
    chk("t5_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0010;
    #1 chk("t5_ready1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t5_id", active_id, 2'd1);
    chk("t5_fs", frame_start, 1'b1);
    chk("t5_bit", serial_out, 1'b1);
    drain();
    // data changes after the handshake must not reach the stream
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    req_data[3:0] = 4'h9;
    #1 chk("t6_ready0", req_ready, 4'b0001);
    w = 4'h9;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = '0;
      req_data[3:0] = 4'h6;
      #1 chk("t6_bit", serial_out, w[3-k]);
    end
    drain();
    // DATA_W=2, NUM_REQ=2: gapless reload on the second bit
    do_reset();
    @(negedge clk);
    v2 = 2'b11;
    d2 = 4'b0110;
    #1 chk("t7_ready0", rdy2, 2'b01);
    s = 16'h0026;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 4) v2 = 2'b00;
      #1;
      chk("t7_bit", so2, s[5-k]);
      chk("t7_valid", sv2, 1'b1);
      chk("t7_fs", fs2, k % 2 == 0);
      chk("t7_id", id2, (k / 2) % 2);
      chk("t7_ready", rdy2, k == 1 ? 2'b10 : k == 3 ? 2'b01 : 2'b00);
    end
    @(negedge clk);
    #1;
    chk("t7_idle", sv2, 1'b0);
    chk("t7_busy", busy2, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
